// File: rtl/uart_word_serializer.sv
// uart_word_serializer
//
// Buffers result words in a small FIFO and hands them to a UART transmitter
// one DATA_WIDTH_OUT-bit beat at a time. Each beat is presented as a one-cycle
// strobe. The next beat is held back until the transmitter reports that the
// current one has finished. An optional header beat can precede every word,
// and the beat order is selectable.
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active low
//   i_data        word to send
//   i_data_valid  word present this cycle
//   o_in_ready    FIFO not full; a word is taken when i_data_valid && o_in_ready
//   tx_done       one-cycle pulse from the transmitter: current beat finished
//   o_data        beat to transmit; holds its value after the strobe
//   o_data_valid  one-cycle strobe qualifying o_data
//   o_busy        engine is working on a word (not idle)
//   o_fifo_count  words currently buffered in the FIFO
//   o_overflow    one-cycle pulse: a word was offered while full and was dropped

module uart_word_serializer #(
   parameter int                        DATA_WIDTH_IN  = 40,
   parameter int                        DATA_WIDTH_OUT = 8,
   parameter int                        FIFO_DEPTH     = 4,
   parameter int                        MSB_FIRST      = 1,
   parameter int                        SYNC_EN        = 0,
   parameter logic [DATA_WIDTH_OUT-1:0] SYNC_BYTE      = 8'hA5,
   localparam int                       CW             = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH_IN-1:0]  i_data,
   input  logic                      i_data_valid,
   output logic                      o_in_ready,
   input  logic                      tx_done,
   output logic [DATA_WIDTH_OUT-1:0] o_data,
   output logic                      o_data_valid,
   output logic                      o_busy,
   output logic [CW-1:0]             o_fifo_count,
   output logic                      o_overflow
);

   localparam int NUM_BEATS = DATA_WIDTH_IN / DATA_WIDTH_OUT;
   localparam int LAST      = NUM_BEATS + SYNC_EN;
   localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int BW        = (LAST > 1) ? $clog2(LAST) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   logic [DATA_WIDTH_IN-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]            wr_ptr;
   logic [AW-1:0]            rd_ptr;
   logic [CW-1:0]            count;
   logic                     push;
   logic                     pop;

   logic [1:0]               state;
   logic [BW-1:0]            beat;
   logic [DATA_WIDTH_IN-1:0] word;

   // Beat b of the word held in the engine. With the header enabled, beat 0
   // is the header and data beats are shifted up by one.
   function automatic logic [DATA_WIDTH_OUT-1:0] beat_value(
      input logic [DATA_WIDTH_IN-1:0] w,
      input logic [BW-1:0]            b
   );
      logic [DATA_WIDTH_IN-1:0] shifted;
      int                       d;
      int                       slot;
      d       = int'(b) - SYNC_EN;
      slot    = (MSB_FIRST != 0) ? (NUM_BEATS - 1 - d) : d;
      shifted = w >> (slot * DATA_WIDTH_OUT);
      if ((SYNC_EN != 0) && (b == '0))
         beat_value = SYNC_BYTE;
      else
         beat_value = shifted[DATA_WIDTH_OUT-1:0];
   endfunction

   assign o_in_ready   = (count != CW'(FIFO_DEPTH));
   assign push         = i_data_valid && o_in_ready;
   assign pop          = (state == IDLE) && (count != '0);
   assign o_busy       = (state != IDLE);
   assign o_fifo_count = count;

   // FIFO storage carries data only; reset clears the pointers and count,
   // which is enough to discard whatever it holds.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= i_data;
      if (pop)
         word <= mem[rd_ptr];
   end

   // FIFO control. Depth is a power of two, so pointers wrap on overflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         o_overflow <= i_data_valid && !o_in_ready;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Beat engine. The strobe is raised on entry to WAIT and dropped after one
   // cycle; a tx_done during that first WAIT cycle still counts.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         beat         <= '0;
         o_data       <= '0;
         o_data_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               o_data_valid <= 1'b0;
               if (pop) begin
                  beat  <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               o_data       <= beat_value(word, beat);
               o_data_valid <= 1'b1;
               state        <= WAIT;
            end
            WAIT: begin
               o_data_valid <= 1'b0;
               if (tx_done) begin
                  if (beat == BW'(LAST - 1)) begin
                     state <= IDLE;
                  end else begin
                     beat  <= beat + 1'b1;
                     state <= SEND;
                  end
               end
            end
            default: begin
               o_data_valid <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule
